dmem_ctrl: RTL and testbench

Parametrised data-memory unit for the RV32IC MEM stage, successor to the single-cycle word-only `dmem`. It adds:
- byte, halfword and word loads and stores, with sign or zero extension on loads
- little-endian byte-lane merging on stores
- misaligned-access and out-of-range detection
- a configurable number of wait states behind a request/response handshake, so the pipeline can stall on slow memory

---
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage and dmem_ctrl.
// Master drives the request fields; slave returns handshake and load data.
interface dmem_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_rdata;
    logic        o_err;

    modport master (
        output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
        input  o_ready, o_busy, o_valid, o_rdata, o_err
    );

    modport slave (
        input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata,
        output o_ready, o_busy, o_valid, o_rdata, o_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory for the MEM stage: byte/half/word loads and stores with extension,
// alignment and range checking, and a configurable number of wait states.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        ready, accept, commit, wr_en;
    logic        op_we, op_uns, op_err;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic [AW-1:0] op_idx;
    logic [31:0] rd_word, rd_shift, load_val, wr_lanes;
    logic [3:0]  be;

    logic [31:0] mem [DEPTH_WORDS];

    assign ready = (state_q == S_IDLE) || (state_q == S_RESP);

    always_comb begin
        accept = bus.i_req && ready;

        // A request finishing its wait phase uses the latched copy; with no wait
        // states the access commits straight from the bus on the accepting edge.
        if (state_q == S_WAIT) begin
            op_we    = we_q;
            op_size  = size_q;
            op_uns   = uns_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end else begin
            op_we    = bus.i_we;
            op_size  = bus.i_size;
            op_uns   = bus.i_unsigned;
            op_addr  = bus.i_addr;
            op_wdata = bus.i_wdata;
        end
        op_idx = op_addr[AW+1:2];

        op_err = (op_size == 2'b11)
              || (op_size == 2'b01 && op_addr[0])
              || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
              || (op_addr[31:2] >= 30'(DEPTH_WORDS));

        rd_word  = mem[op_idx];
        rd_shift = rd_word >> {op_addr[1:0], 3'b000};
        case (op_size)
            2'b00:   load_val = op_uns ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = op_uns ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase

        case (op_size)
            2'b00: begin
                wr_lanes = {4{op_wdata[7:0]}};
                be       = 4'b0001 << op_addr[1:0];
            end
            2'b01: begin
                wr_lanes = {2{op_wdata[15:0]}};
                be       = op_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_lanes = op_wdata;
                be       = 4'b1111;
            end
        endcase

        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    cnt_d   = '0;
                    commit  = (WAIT_CYCLES == 0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            we_d    = bus.i_we;
            size_d  = bus.i_size;
            uns_d   = bus.i_unsigned;
            addr_d  = bus.i_addr;
            wdata_d = bus.i_wdata;
        end

        if (commit) begin
            err_d   = op_err;
            rdata_d = (!op_err && !op_we) ? load_val : '0;
        end

        wr_en = commit && op_we && !op_err && i_rst_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[op_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_busy  = (state_q == S_WAIT) || (state_q == S_RESP);
    assign bus.o_valid = (state_q == S_RESP);
    assign bus.o_rdata = rdata_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states, one with three.
module tb_dmem_ctrl;
    logic i_clk;
    logic rst0_n, rst3_n;
    int   checks   = 0;
    int   failures = 0;

    dmem_ctrl_if if0 ();
    dmem_ctrl_if if3 ();

    dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk   (i_clk),
        .i_rst_n (rst0_n),
        .bus     (if0.slave)
    );

    dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk   (i_clk),
        .i_rst_n (rst3_n),
        .bus     (if3.slave)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag, input logic which);
        if (!which) begin
            chk({tag, "_ready"}, {31'b0, if0.o_ready}, 32'd1);
            chk({tag, "_busy"},  {31'b0, if0.o_busy},  32'd0);
            chk({tag, "_valid"}, {31'b0, if0.o_valid}, 32'd0);
            chk({tag, "_rdata"}, if0.o_rdata,          32'd0);
            chk({tag, "_err"},   {31'b0, if0.o_err},   32'd0);
        end else begin
            chk({tag, "_ready"}, {31'b0, if3.o_ready}, 32'd1);
            chk({tag, "_busy"},  {31'b0, if3.o_busy},  32'd0);
            chk({tag, "_valid"}, {31'b0, if3.o_valid}, 32'd0);
            chk({tag, "_rdata"}, if3.o_rdata,          32'd0);
            chk({tag, "_err"},   {31'b0, if3.o_err},   32'd0);
        end
    endtask

    // Called just after a rising edge with the zero-wait instance idle.
    task automatic acc0(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        if0.i_req = 1'b1; if0.i_we = we; if0.i_size = size;
        if0.i_unsigned = uns; if0.i_addr = addr; if0.i_wdata = wdata;
        @(posedge i_clk); #1;
        if0.i_req = 1'b0;
        @(negedge i_clk);
        chk({tag, "_valid"}, {31'b0, if0.o_valid}, 32'd1);
        chk({tag, "_rdata"}, if0.o_rdata, exp_rd);
        chk({tag, "_err"},   {31'b0, if0.o_err}, {31'b0, exp_err});
        @(posedge i_clk); #1;
    endtask

    // Three-wait instance; request fields are scrambled while the access is in flight.
    task automatic acc3(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        if3.i_req = 1'b1; if3.i_we = we; if3.i_size = size;
        if3.i_unsigned = uns; if3.i_addr = addr; if3.i_wdata = wdata;
        @(posedge i_clk); #1;
        for (int k = 1; k <= 3; k++) begin
            if3.i_req   = 1'b0;
            if3.i_addr  = $urandom;
            if3.i_wdata = $urandom;
            if3.i_we    = 1'($urandom_range(0, 1));
            if3.i_size  = 2'($urandom_range(0, 3));
            @(negedge i_clk);
            chk($sformatf("%s_c%0d_ready", tag, k), {31'b0, if3.o_ready}, 32'd0);
            chk($sformatf("%s_c%0d_busy", tag, k),  {31'b0, if3.o_busy},  32'd1);
            chk($sformatf("%s_c%0d_valid", tag, k), {31'b0, if3.o_valid}, 32'd0);
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        chk({tag, "_valid"}, {31'b0, if3.o_valid}, 32'd1);
        chk({tag, "_rdata"}, if3.o_rdata, exp_rd);
        chk({tag, "_err"},   {31'b0, if3.o_err}, {31'b0, exp_err});
        @(posedge i_clk); #1;
    endtask

    initial begin
        if0.i_req = 1'b0; if0.i_we = 1'b0; if0.i_size = 2'b00;
        if0.i_unsigned = 1'b0; if0.i_addr = '0; if0.i_wdata = '0;
        if3.i_req = 1'b0; if3.i_we = 1'b0; if3.i_size = 2'b00;
        if3.i_unsigned = 1'b0; if3.i_addr = '0; if3.i_wdata = '0;
        rst0_n = 1'b1; rst3_n = 1'b1;
        #1 rst0_n = 1'b0; rst3_n = 1'b0;
        #2;
        idle_outputs("rst0", 1'b0);
        idle_outputs("rst3", 1'b1);
        @(posedge i_clk); @(posedge i_clk); #1;
        rst0_n = 1'b1; rst3_n = 1'b1;
        @(posedge i_clk); #1;

        acc0("sw_10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc0("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        acc0("sb_13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 32'h0, 1'b0);
        acc0("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        acc0("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
        acc0("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        acc0("sh_10",  1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD1234, 32'h0, 1'b0);
        acc0("lh_10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00001234, 1'b0);
        acc0("sh_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h5555F00D, 32'h0, 1'b0);
        acc0("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFF00D, 1'b0);
        acc0("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000F00D, 1'b0);
        acc0("lbu_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h0000000D, 1'b0);
        acc0("lw_10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hF00D1234, 1'b0);

        acc0("lh_11",  1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        acc0("sw_12",  1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        acc0("lw_10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hF00D1234, 1'b0);
        acc0("rsv",    1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        acc0("lw_oor", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        acc0("sw_oor", 1'b1, 2'b10, 1'b0, 32'h110, 32'h77777777, 32'h0, 1'b1);
        acc0("lw_10e", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hF00D1234, 1'b0);
        acc0("sw_fc",  1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0);
        acc0("lw_fc",  1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
        @(negedge i_clk);
        idle_outputs("after_resp", 1'b0);
        @(posedge i_clk); #1;

        // Back-to-back with request held: the load is accepted in the store's RESP cycle.
        if0.i_req = 1'b1; if0.i_we = 1'b1; if0.i_size = 2'b10;
        if0.i_unsigned = 1'b0; if0.i_addr = 32'h20; if0.i_wdata = 32'h0000AAAA;
        @(posedge i_clk); #1;
        if0.i_we = 1'b0; if0.i_wdata = '0;
        @(negedge i_clk);
        chk("b2b_st_valid", {31'b0, if0.o_valid}, 32'd1);
        chk("b2b_st_ready", {31'b0, if0.o_ready}, 32'd1);
        chk("b2b_st_rdata", if0.o_rdata, 32'd0);
        @(posedge i_clk); #1;
        if0.i_req = 1'b0;
        @(negedge i_clk);
        chk("b2b_ld_valid", {31'b0, if0.o_valid}, 32'd1);
        chk("b2b_ld_rdata", if0.o_rdata, 32'h0000AAAA);
        chk("b2b_ld_err",   {31'b0, if0.o_err}, 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        idle_outputs("b2b_end", 1'b0);
        @(posedge i_clk); #1;

        acc3("w3_sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, 32'h0, 1'b0);
        acc3("w3_lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0);
        acc3("w3_lbu31", 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h00000011, 1'b0);
        acc3("w3_lw31", 1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1);

        // Reset during WAIT drops the pending store.
        if3.i_req = 1'b1; if3.i_we = 1'b1; if3.i_size = 2'b10;
        if3.i_unsigned = 1'b0; if3.i_addr = 32'h30; if3.i_wdata = 32'h55555555;
        @(posedge i_clk); #1;
        if3.i_req = 1'b0;
        @(negedge i_clk);
        chk("rstw_c1_busy", {31'b0, if3.o_busy}, 32'd1);
        @(posedge i_clk); #1;
        rst3_n = 1'b0;
        #1;
        idle_outputs("rstw_c2", 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
        end
        rst3_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk($sformatf("rstw_novalid%0d", k), {31'b0, if3.o_valid}, 32'd0);
            @(posedge i_clk); #1;
        end
        acc3("rstw_lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
